// File: rtl/sram_fault_pkg.sv
// Shared encodings for the SRAM fault model: fault types and the
// arming FSM states.
package sram_fault_pkg;

  typedef enum logic [1:0] {
    FLT_NONE = 2'd0,
    FLT_SA0  = 2'd1,
    FLT_SA1  = 2'd2,
    FLT_CPL  = 2'd3
  } flt_type_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } flt_state_e;

endpackage

// File: rtl/sram_fault_ctrl.sv
// Fault descriptor registers, arming FSM and victim-bit mask generation.
// Fault injection is only built when SRAM_FAULT_INJ_EN is defined;
// otherwise the masks are neutral and FLT_ACTIVE is tied low.
module sram_fault_ctrl
  import sram_fault_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flt_load_i,
  input  logic [1:0]    flt_type_i,
  input  logic [AW-1:0] flt_addr_i,
  input  logic [2:0]    flt_bit_i,
  input  logic [AW-1:0] flt_aggr_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  output logic          flt_active_o,
  output logic [DW-1:0] and_mask_o,
  output logic [DW-1:0] or_mask_o,
  output logic [DW-1:0] xor_mask_o,
  output logic          cpl_we_o,
  output logic [AW-1:0] cpl_addr_o,
  output logic [DW-1:0] cpl_mask_o
);

`ifdef SRAM_FAULT_INJ_EN
  flt_state_e    state_q, state_d;
  flt_type_e     type_q;
  logic [AW-1:0] vaddr_q;
  logic [AW-1:0] aggr_q;
  logic [2:0]    bit_q;
  logic          bit_ok;
  logic [DW-1:0] bit_mask;

  // Arming FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Descriptor capture; takes effect on the cycle after the load pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      type_q  <= FLT_NONE;
      vaddr_q <= '0;
      aggr_q  <= '0;
      bit_q   <= '0;
    end else if (flt_load_i) begin
      type_q  <= flt_type_e'(flt_type_i);
      vaddr_q <= flt_addr_i;
      aggr_q  <= flt_aggr_i;
      bit_q   <= flt_bit_i;
    end
  end

  // Next state: a load with a non-zero type arms, a load of type 0 disarms.
  always_comb begin
    state_d = state_q;
    if (flt_load_i) state_d = (flt_type_i != FLT_NONE) ? ST_ARMED : ST_IDLE;
  end

  // FSM output.
  always_comb begin
    flt_active_o = (state_q == ST_ARMED);
  end

  // Victim-bit masks for the current access; a victim bit beyond DW disables all effects.
  always_comb begin
    and_mask_o = '1;
    or_mask_o  = '0;
    xor_mask_o = '0;
    cpl_we_o   = 1'b0;
    cpl_addr_o = vaddr_q;
    cpl_mask_o = '0;
    bit_ok     = ({29'd0, bit_q} < 32'(DW));
    bit_mask   = bit_ok ? (DW'(1) << bit_q) : '0;
    if (state_q == ST_ARMED) begin
      unique case (type_q)
        FLT_SA0: if (addr_i == vaddr_q) and_mask_o = ~bit_mask;
        FLT_SA1: if (addr_i == vaddr_q) or_mask_o = bit_mask;
        FLT_CPL: begin
          if (we_i && (addr_i == aggr_q)) begin
            if (aggr_q == vaddr_q) begin
              xor_mask_o = bit_mask;
            end else begin
              cpl_we_o   = bit_ok;
              cpl_mask_o = bit_mask;
            end
          end
        end
        default: ;
      endcase
    end
  end
`else
  logic unused_flt;

  // Plain SRAM build: fault inputs are ignored and masks are neutral.
  always_comb begin
    unused_flt   = ^{clk_i, rst_i, flt_load_i, flt_type_i, flt_addr_i,
                     flt_bit_i, flt_aggr_i, we_i, addr_i};
    flt_active_o = 1'b0;
    and_mask_o   = '1;
    or_mask_o    = '0;
    xor_mask_o   = '0;
    cpl_we_o     = 1'b0;
    cpl_addr_o   = '0;
    cpl_mask_o   = '0;
  end
`endif

endmodule

// File: rtl/sram_fault_model.sv
// Single-port SRAM model for MBIST with an optional injectable fault
// (stuck-at-0/1 or inversion coupling), enabled by SRAM_FAULT_INJ_EN.
// Array contents survive reset; read data is registered (1-cycle latency).
module sram_fault_model
  import sram_fault_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          CLK,
  input  logic          nRESET,
  input  logic          iWrite,
  input  logic          iRead,
  input  logic [AW-1:0] ADDR_MBIST,
  input  logic [DW-1:0] DATA_MBIST,
  output logic [DW-1:0] DATA_DUT,
  input  logic          FLT_LOAD,
  input  logic [1:0]    FLT_TYPE,
  input  logic [AW-1:0] FLT_ADDR,
  input  logic [2:0]    FLT_BIT,
  input  logic [AW-1:0] FLT_AGGR,
  output logic          FLT_ACTIVE
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] and_mask;
  logic [DW-1:0] or_mask;
  logic [DW-1:0] xor_mask;
  logic          cpl_we;
  logic [AW-1:0] cpl_addr;
  logic [DW-1:0] cpl_mask;

  sram_fault_ctrl #(
    .AW(AW),
    .DW(DW)
  ) u_ctrl (
    .clk_i       (CLK),
    .rst_i       (nRESET),
    .flt_load_i  (FLT_LOAD),
    .flt_type_i  (FLT_TYPE),
    .flt_addr_i  (FLT_ADDR),
    .flt_bit_i   (FLT_BIT),
    .flt_aggr_i  (FLT_AGGR),
    .we_i        (iWrite),
    .addr_i      (ADDR_MBIST),
    .flt_active_o(FLT_ACTIVE),
    .and_mask_o  (and_mask),
    .or_mask_o   (or_mask),
    .xor_mask_o  (xor_mask),
    .cpl_we_o    (cpl_we),
    .cpl_addr_o  (cpl_addr),
    .cpl_mask_o  (cpl_mask)
  );

  // Array write plus coupling flip of a separate victim word; reset high blocks the write.
  always_ff @(posedge CLK) begin
    if (!nRESET) begin
      if (iWrite) mem[ADDR_MBIST] <= ((DATA_MBIST & and_mask) | or_mask) ^ xor_mask;
      if (cpl_we) mem[cpl_addr] <= mem[cpl_addr] ^ cpl_mask;
    end
  end

  // Registered read returns the pre-write word; stuck-at forcing applies on the way out.
  always_ff @(posedge CLK or posedge nRESET) begin
    if (nRESET)     rdata_q <= '0;
    else if (iRead) rdata_q <= (mem[ADDR_MBIST] & and_mask) | or_mask;
  end

  assign DATA_DUT = rdata_q;

endmodule

// File: tb/tb_sram_fault_model.sv
// Directed self-checking bench for sram_fault_model. Expectations for the
// fault scenarios follow whether SRAM_FAULT_INJ_EN is defined in this build.
module tb_sram_fault_model;

`ifdef SRAM_FAULT_INJ_EN
  localparam bit FI = 1'b1;
`else
  localparam bit FI = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       nRESET = 1'b1;
  logic       iWrite = 1'b0;
  logic       iRead = 1'b0;
  logic [7:0] ADDR_MBIST = '0;
  logic [7:0] DATA_MBIST = '0;
  logic [7:0] DATA_DUT;
  logic       FLT_LOAD = 1'b0;
  logic [1:0] FLT_TYPE = '0;
  logic [7:0] FLT_ADDR = '0;
  logic [2:0] FLT_BIT = '0;
  logic [7:0] FLT_AGGR = '0;
  logic       FLT_ACTIVE;

  int tests = 0;
  int fails = 0;

  sram_fault_model #(.AW(8), .DW(8), .DEPTH(256)) dut (
    .CLK       (CLK),
    .nRESET    (nRESET),
    .iWrite    (iWrite),
    .iRead     (iRead),
    .ADDR_MBIST(ADDR_MBIST),
    .DATA_MBIST(DATA_MBIST),
    .DATA_DUT  (DATA_DUT),
    .FLT_LOAD  (FLT_LOAD),
    .FLT_TYPE  (FLT_TYPE),
    .FLT_ADDR  (FLT_ADDR),
    .FLT_BIT   (FLT_BIT),
    .FLT_AGGR  (FLT_AGGR),
    .FLT_ACTIVE(FLT_ACTIVE)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    iWrite = 1'b1; ADDR_MBIST = a; DATA_MBIST = d;
    tick();
    iWrite = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a);
    iRead = 1'b1; ADDR_MBIST = a;
    tick();
    iRead = 1'b0;
  endtask

  task automatic do_load(input logic [1:0] t, input logic [7:0] v,
                         input logic [2:0] b, input logic [7:0] g);
    FLT_LOAD = 1'b1; FLT_TYPE = t; FLT_ADDR = v; FLT_BIT = b; FLT_AGGR = g;
    tick();
    FLT_LOAD = 1'b0;
  endtask

  task automatic test_reset();
    nRESET = 1'b1;
    tick(); tick();
    tests++;
    if (DATA_DUT !== 8'h00) begin
      fails++; $display("FAIL reset_data: got %h expected 00", DATA_DUT);
    end
    tests++;
    if (FLT_ACTIVE !== 1'b0) begin
      fails++; $display("FAIL reset_active: got %b expected 0", FLT_ACTIVE);
    end
    nRESET = 1'b0;
    tick();
  endtask

  task automatic test_basic_rw();
    logic [7:0] addrs [3] = '{8'h00, 8'hFF, 8'h7F};
    logic [7:0] datas [3] = '{8'hA5, 8'h3C, 8'h01};
    do_write(8'h10, 8'h55);
    do_read(8'h10);
    tests++;
    if (DATA_DUT !== 8'h55) begin
      fails++; $display("FAIL rw_55: got %h expected 55", DATA_DUT);
    end
    ADDR_MBIST = 8'h00;
    tick();
    tests++;
    if (DATA_DUT !== 8'h55) begin
      fails++; $display("FAIL rw_hold: got %h expected 55", DATA_DUT);
    end
    for (int i = 0; i < 3; i++) do_write(addrs[i], datas[i]);
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i]);
      tests++;
      if (DATA_DUT !== datas[i]) begin
        fails++; $display("FAIL rw_pattern[%0d]: got %h expected %h", i, DATA_DUT, datas[i]);
      end
    end
  endtask

  task automatic test_same_cycle();
    do_write(8'h30, 8'h11);
    iWrite = 1'b1; iRead = 1'b1; ADDR_MBIST = 8'h30; DATA_MBIST = 8'hAA;
    tick();
    iWrite = 1'b0; iRead = 1'b0;
    tests++;
    if (DATA_DUT !== 8'h11) begin
      fails++; $display("FAIL same_cycle_old: got %h expected 11", DATA_DUT);
    end
    do_read(8'h30);
    tests++;
    if (DATA_DUT !== 8'hAA) begin
      fails++; $display("FAIL same_cycle_new: got %h expected aa", DATA_DUT);
    end
  endtask

  task automatic test_stuck_at();
    do_load(2'd1, 8'h20, 3'd0, 8'h00);
    tests++;
    if (FLT_ACTIVE !== FI) begin
      fails++; $display("FAIL sa0_active: got %b expected %b", FLT_ACTIVE, FI);
    end
    do_write(8'h20, 8'hFF);
    do_read(8'h20);
    tests++;
    if (DATA_DUT !== (FI ? 8'hFE : 8'hFF)) begin
      fails++; $display("FAIL sa0_read: got %h expected %h", DATA_DUT, FI ? 8'hFE : 8'hFF);
    end
    do_load(2'd2, 8'h21, 3'd3, 8'h00);
    do_write(8'h21, 8'h00);
    do_read(8'h21);
    tests++;
    if (DATA_DUT !== (FI ? 8'h08 : 8'h00)) begin
      fails++; $display("FAIL sa1_read: got %h expected %h", DATA_DUT, FI ? 8'h08 : 8'h00);
    end
    // Disarm: the word stored under SA0 keeps the forced bit.
    do_load(2'd0, 8'h00, 3'd0, 8'h00);
    tests++;
    if (FLT_ACTIVE !== 1'b0) begin
      fails++; $display("FAIL disarm_active: got %b expected 0", FLT_ACTIVE);
    end
    do_read(8'h20);
    tests++;
    if (DATA_DUT !== (FI ? 8'hFE : 8'hFF)) begin
      fails++; $display("FAIL sa0_stored: got %h expected %h", DATA_DUT, FI ? 8'hFE : 8'hFF);
    end
    do_write(8'h20, 8'hFF);
    do_read(8'h20);
    tests++;
    if (DATA_DUT !== 8'hFF) begin
      fails++; $display("FAIL disarm_read: got %h expected ff", DATA_DUT);
    end
  endtask

  task automatic test_coupling();
    do_load(2'd3, 8'h02, 3'd7, 8'h01);
    do_write(8'h02, 8'h00);
    do_write(8'h01, 8'h5A);
    do_read(8'h02);
    tests++;
    if (DATA_DUT !== (FI ? 8'h80 : 8'h00)) begin
      fails++; $display("FAIL cpl_victim: got %h expected %h", DATA_DUT, FI ? 8'h80 : 8'h00);
    end
    do_read(8'h01);
    tests++;
    if (DATA_DUT !== 8'h5A) begin
      fails++; $display("FAIL cpl_aggr: got %h expected 5a", DATA_DUT);
    end
    do_write(8'h01, 8'h33);
    do_read(8'h02);
    tests++;
    if (DATA_DUT !== 8'h00) begin
      fails++; $display("FAIL cpl_reflip: got %h expected 00", DATA_DUT);
    end
    // Aggressor and victim on the same word.
    do_load(2'd3, 8'h03, 3'd1, 8'h03);
    do_write(8'h03, 8'h00);
    do_read(8'h03);
    tests++;
    if (DATA_DUT !== (FI ? 8'h02 : 8'h00)) begin
      fails++; $display("FAIL cpl_same: got %h expected %h", DATA_DUT, FI ? 8'h02 : 8'h00);
    end
  endtask

  task automatic test_load_cycle();
    do_write(8'h06, 8'h00);
    // Write to the new aggressor in the load cycle itself: old descriptor applies.
    FLT_LOAD = 1'b1; FLT_TYPE = 2'd3; FLT_ADDR = 8'h06; FLT_BIT = 3'd2; FLT_AGGR = 8'h05;
    iWrite = 1'b1; ADDR_MBIST = 8'h05; DATA_MBIST = 8'h77;
    tick();
    FLT_LOAD = 1'b0; iWrite = 1'b0;
    do_read(8'h06);
    tests++;
    if (DATA_DUT !== 8'h00) begin
      fails++; $display("FAIL load_cycle_old: got %h expected 00", DATA_DUT);
    end
    do_write(8'h05, 8'h77);
    do_read(8'h06);
    tests++;
    if (DATA_DUT !== (FI ? 8'h04 : 8'h00)) begin
      fails++; $display("FAIL load_cycle_new: got %h expected %h", DATA_DUT, FI ? 8'h04 : 8'h00);
    end
  endtask

  task automatic test_reset_mid();
    do_read(8'h06);
    // Start a write of 0x00 to 0x10, then reset before its edge.
    iWrite = 1'b1; ADDR_MBIST = 8'h10; DATA_MBIST = 8'h00;
    #2;
    nRESET = 1'b1;
    #1;
    tests++;
    if (DATA_DUT !== 8'h00) begin
      fails++; $display("FAIL mid_reset_data: got %h expected 00", DATA_DUT);
    end
    tests++;
    if (FLT_ACTIVE !== 1'b0) begin
      fails++; $display("FAIL mid_reset_active: got %b expected 0", FLT_ACTIVE);
    end
    tick();
    iWrite = 1'b0;
    nRESET = 1'b0;
    tick();
    do_read(8'h10);
    tests++;
    if (DATA_DUT !== 8'h55) begin
      fails++; $display("FAIL mid_reset_keep: got %h expected 55", DATA_DUT);
    end
    // Coupling was disarmed by reset: aggressor write leaves victim alone.
    do_write(8'h05, 8'h12);
    do_read(8'h06);
    tests++;
    if (DATA_DUT !== (FI ? 8'h04 : 8'h00)) begin
      fails++; $display("FAIL mid_reset_disarm: got %h expected %h", DATA_DUT, FI ? 8'h04 : 8'h00);
    end
  endtask

  initial begin
    test_reset();
    test_basic_rw();
    test_same_cycle();
    test_stuck_at();
    test_coupling();
    test_load_cycle();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
